// File: rtl/keypad_pkg.sv
// Shared types, key map and row-priority helper for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} kp_state_t;

  // Indexed [row][col]
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  // Rows are active-low; the lowest-index low row wins.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus decoded key outputs; master is the scanner, slave the board/consumer side.
interface keypad_scanner_if;
  logic [3:0] row_pi;
  logic [3:0] col_po;
  logic [3:0] tecla_po;
  logic       tecla_valid_po;
  logic       tecla_held_po;

  modport master (
    input  row_pi,
    output col_po,
    output tecla_po,
    output tecla_valid_po,
    output tecla_held_po
  );

  modport slave (
    output row_pi,
    input  col_po,
    input  tecla_po,
    input  tecla_valid_po,
    input  tecla_held_po
  );
endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchroniser; resets to all-ones so idle pulled-up rows read as released.
module keypad_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_pi,
  input  logic             rst_n_pi,
  input  logic [WIDTH-1:0] d_pi,
  output logic [WIDTH-1:0] q_po
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      meta_q <= '1;
      q_po   <= '1;
    end else begin
      meta_q <= d_pi;
      q_po   <= meta_q;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, row debounce, one valid pulse per accepted press.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic              clk_pi,
  input  logic              rst_n_pi,
  keypad_scanner_if.master  kp
);

  localparam int unsigned MaxSd = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned MaxP  = (MaxSd > REPEAT_CYCLES) ? MaxSd : REPEAT_CYCLES;
  localparam int unsigned CntW  = $clog2(MaxP) + 1;

  localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_CYCLES - 1);
  localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);

  kp_state_t       state_q, state_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [CntW-1:0] scan_cnt_q, scan_cnt_d;
  logic [CntW-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]      tecla_q, tecla_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;
  logic [3:0]      rows_s;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CntW-1:0] RepLast = CntW'(REPEAT_CYCLES - 1);
  logic [CntW-1:0] rep_cnt_q, rep_cnt_d;
`endif

  keypad_sync #(
    .WIDTH (4)
  ) u_row_sync (
    .clk_pi   (clk_pi),
    .rst_n_pi (rst_n_pi),
    .d_pi     (kp.row_pi),
    .q_po     (rows_s)
  );

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    row_idx_d  = row_idx_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    tecla_d    = tecla_q;
    valid_d    = 1'b0;
    held_d     = held_q;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
`endif
    unique case (state_q)
      SCAN: begin
        if (scan_cnt_q == ScanLast) begin
          scan_cnt_d = '0;
          if (rows_s == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d = lowest_low_row(rows_s);
            deb_cnt_d = '0;
            state_d   = DEBOUNCE;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!rows_s[row_idx_q]) begin
          if (deb_cnt_q == DebLast) begin
            deb_cnt_d = '0;
            tecla_d   = KEY_MAP[row_idx_q][col_idx_q];
            valid_d   = 1'b1;
            held_d    = 1'b1;
            state_d   = PRESSED;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end else begin
          // Rejected press: move on so a stuck bounce cannot pin the scan on one column.
          deb_cnt_d  = '0;
          col_idx_d  = col_idx_q + 2'd1;
          scan_cnt_d = '0;
          state_d    = SCAN;
        end
      end
      PRESSED: begin
        if (rows_s[row_idx_q]) begin
          deb_cnt_d = '0;
          state_d   = RELEASE;
`ifdef KEYPAD_REPEAT_EN
          rep_cnt_d = '0;
        end else if (rep_cnt_q == RepLast) begin
          valid_d   = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
`endif
        end
      end
      RELEASE: begin
        if (rows_s[row_idx_q]) begin
          if (deb_cnt_q == DebLast) begin
            deb_cnt_d  = '0;
            held_d     = 1'b0;
            col_idx_d  = col_idx_q + 2'd1;
            scan_cnt_d = '0;
            state_d    = SCAN;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end else begin
          deb_cnt_d = '0;
          state_d   = PRESSED;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      state_q    <= SCAN;
      col_idx_q  <= 2'd0;
      row_idx_q  <= 2'd0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      tecla_q    <= 4'h0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      row_idx_q  <= row_idx_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      tecla_q    <= tecla_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
`endif
    end
  end

  assign kp.col_po         = ~(4'b0001 << col_idx_q);
  assign kp.tecla_po       = tecla_q;
  assign kp.tecla_valid_po = valid_q;
  assign kp.tecla_held_po  = held_q;

endmodule
